// File: rtl/des_pkg.sv
// DES key-schedule constants: shift schedule, PC-1/PC-2 index tables and
// the half-key rotation helpers shared by the sequencer and its PC-2 stage.
package des_pkg;

    localparam int SK_W   = 48;
    localparam int HALF_W = 28;
    localparam int CD_W   = 2 * HALF_W;
    localparam int KEY_W  = 64;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    localparam logic [1:0] SHIFT [1:16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Entries are DES bit numbers (1 = MSB) into the 64-bit key.
    localparam int PC1 [1:CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // Entries are DES bit numbers (1 = MSB) into the 56-bit {C,D}.
    localparam int PC2 [1:SK_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [1:HALF_W] rotl28(input logic [1:HALF_W] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[3:HALF_W], x[1:2]} : {x[2:HALF_W], x[1]};
    endfunction

    function automatic logic [1:HALF_W] rotr28(input logic [1:HALF_W] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[HALF_W-1:HALF_W], x[1:HALF_W-2]}
                           : {x[HALF_W], x[1:HALF_W-1]};
    endfunction

    function automatic logic [1:CD_W] rot_cd(input logic [1:CD_W] cd, input logic [1:0] n,
                                             input logic left);
        return left ? {rotl28(cd[1:HALF_W], n), rotl28(cd[HALF_W+1:CD_W], n)}
                    : {rotr28(cd[1:HALF_W], n), rotr28(cd[HALF_W+1:CD_W], n)};
    endfunction

    function automatic logic [1:0] shift_of(input logic [4:0] r);
        logic [1:0] s;
        s = 2'd1;
        for (int i = 1; i <= 16; i++) begin
            if (r == 5'(i)) s = SHIFT[i];
        end
        return s;
    endfunction

    function automatic logic [1:CD_W] pc1_perm(input logic [1:KEY_W] k);
        logic [1:CD_W] r;
        for (int i = 1; i <= CD_W; i++) r[i] = k[PC1[i]];
        return r;
    endfunction

    function automatic logic parity_bad(input logic [1:KEY_W] k);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (~^k[b*8+1 +: 8]) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression: pure wiring from the running {C,D} register to the subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [1:CD_W] cd_i,
    output logic [1:SK_W] sk_o
);

    always_comb begin
        sk_o = '0;
        for (int i = 1; i <= SK_W; i++) sk_o[i] = cd_i[PC2[i]];
    end

endmodule

// File: rtl/des_key_sched.sv
// DES key-schedule sequencer: one running {C,D} register rotated per round,
// emitting PC-2 subkeys K1..K16 (encrypt) or K16..K1 (decrypt) on a valid/ready stream.
//
// state   | meaning
// ST_IDLE | waiting for a key; key_ready high
// ST_RUN  | presenting the subkey for round_q; advances on each handshake
module des_key_sched
    import des_pkg::*;
#(
    parameter bit CHECK_PARITY = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    output logic          key_ready,
    input  logic [1:64]   key,
    input  logic          decrypt,
    output logic          sk_valid,
    input  logic          sk_ready,
    output logic [1:48]   sk,
    output logic [4:0]    sk_round,
    output logic          sk_last,
    output logic          key_parity_err
);

    state_t          state_q, state_d;
    logic [1:CD_W]   cd_q, cd_d;
    logic [4:0]      round_q, round_d;
    logic            dec_q, dec_d;
    logic            perr_q, perr_d;
    logic [1:CD_W]   cd_pc1;
    logic            last_rnd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cd_q    <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            round_q <= round_d;
            dec_q   <= dec_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cd_d      = cd_q;
        round_d   = round_q;
        dec_d     = dec_q;
        perr_d    = perr_q;
        cd_pc1    = pc1_perm(key);
        last_rnd  = dec_q ? (round_q == 5'd1) : (round_q == 5'd16);
        key_ready = (state_q == ST_IDLE);
        sk_valid  = (state_q == ST_RUN);
        sk_last   = (state_q == ST_RUN) && last_rnd;

        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    state_d = ST_RUN;
                    dec_d   = decrypt;
                    perr_d  = CHECK_PARITY ? parity_bad(key) : 1'b0;
                    // Total rotation over 16 rounds is 28, so C16/D16 equal C0/D0.
                    if (decrypt) begin
                        cd_d    = cd_pc1;
                        round_d = 5'd16;
                    end else begin
                        cd_d    = rot_cd(cd_pc1, SHIFT[1], 1'b1);
                        round_d = 5'd1;
                    end
                end
            end
            ST_RUN: begin
                if (sk_ready) begin
                    if (last_rnd) begin
                        state_d = ST_IDLE;
                    end else if (dec_q) begin
                        cd_d    = rot_cd(cd_q, shift_of(round_q), 1'b0);
                        round_d = round_q - 5'd1;
                    end else begin
                        cd_d    = rot_cd(cd_q, shift_of(round_q + 5'd1), 1'b1);
                        round_d = round_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    des_pc2 u_pc2 (
        .cd_i (cd_q),
        .sk_o (sk)
    );

    assign sk_round       = round_q;
    assign key_parity_err = perr_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Scoreboard bench for des_key_sched: a DES key-schedule model computed from
// cumulative shifts feeds an expected-subkey queue checked by a monitor.
module tb_des_key_sched;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_AP = 64'h133457799BBCDFF0;
    localparam logic [47:0] K1_A   = 48'h1B02EFFC7072;
    localparam logic [47:0] K2_A   = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16_A  = 48'hCB3D8B0E17F5;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key;
    logic        decrypt;
    logic        sk_valid;
    logic        sk_ready;
    logic [47:0] sk;
    logic [4:0]  sk_round;
    logic        sk_last;
    logic        key_parity_err;

    typedef struct {
        logic [47:0] sk;
        logic [4:0]  rnd;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   hs_cnt = 0;
    int   valid_cycles = 0;
    bit   rdy_rand = 1'b0;

    des_key_sched #(.CHECK_PARITY(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .key_valid      (key_valid),
        .key_ready      (key_ready),
        .key            (key),
        .decrypt        (decrypt),
        .sk_valid       (sk_valid),
        .sk_ready       (sk_ready),
        .sk             (sk),
        .sk_round       (sk_round),
        .sk_last        (sk_last),
        .key_parity_err (key_parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Round r subkey: C_r/D_r are C0/D0 rotated left by the cumulative shift.
    function automatic logic [47:0] model_subkey(input logic [63:0] k, input int r);
        logic [55:0] cd0, cdr;
        logic [47:0] o;
        int s;
        for (int j = 1; j <= 56; j++) cd0[56-j] = k[64-PC1_T[j-1]];
        s = 0;
        for (int i = 0; i < r; i++) s += SH_T[i];
        for (int j = 1; j <= 28; j++) begin
            cdr[56-j] = cd0[56-(((j-1+s)%28)+1)];
            cdr[28-j] = cd0[28-(((j-1+s)%28)+1)];
        end
        for (int m = 1; m <= 48; m++) o[48-m] = cdr[56-PC2_T[m-1]];
        return o;
    endfunction

    function automatic logic model_parity_bad(input logic [63:0] k);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) if ((^k[b*8 +: 8]) == 1'b0) bad = 1'b1;
        return bad;
    endfunction

    task automatic model_push(input logic [63:0] k, input logic dec);
        exp_t e;
        for (int i = 1; i <= 16; i++) begin
            int r;
            r = dec ? 17 - i : i;
            e.sk   = model_subkey(k, r);
            e.rnd  = 5'(r);
            e.last = (i == 16);
            sb.push_back(e);
        end
    endtask

    // Monitor: every accepted subkey is compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && sk_valid === 1'b1) begin
                valid_cycles++;
                if (sk_ready === 1'b1) begin
                    hs_cnt++;
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_subkey: got sk=%h round=%0d expected none", sk, sk_round);
                    end else begin
                        e = sb.pop_front();
                        chk("subkey{sk,round,last}", 64'({sk, sk_round, sk_last}),
                            64'({e.sk, e.rnd, e.last}));
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) sk_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_key(input logic [63:0] k, input logic dec);
        bit ok;
        @(posedge clk);
        #1;
        key_valid = 1'b1;
        key       = k;
        decrypt   = dec;
        ok        = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (key_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("key_accept_timeout", 64'(ok), 64'(1));
        if (ok) model_push(k, dec);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_round(input int r);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sk_valid === 1'b1 && sk_round == 5'(r)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_round_timeout", 64'(ok), 64'(1));
    endtask

    task automatic drain_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk("drain_timeout", 64'(ok), 64'(1));
        @(negedge clk);
        chk("idle_key_ready", 64'(key_ready), 64'(1));
        chk("idle_sk_valid", 64'(sk_valid), 64'(0));
    endtask

    initial begin
        logic [47:0] held_sk;
        rst       = 1'b1;
        key_valid = 1'b0;
        key       = '0;
        decrypt   = 1'b0;
        sk_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_key_ready", 64'(key_ready), 64'(1));
        chk("reset_state", 64'({sk_valid, sk_last, key_parity_err, sk_round}), 64'(0));
        chk("reset_sk", 64'(sk), 64'(0));

        // Encrypt, full rate.
        send_key(KEY_A, 1'b0);
        valid_cycles = 0;
        hs_cnt       = 0;
        @(negedge clk);
        chk("enc_K1", 64'(sk), 64'(K1_A));
        chk("enc_K1_round", 64'(sk_round), 64'(1));
        chk("enc_parity_ok", 64'(key_parity_err), 64'(0));
        @(negedge clk);
        chk("enc_K2", 64'(sk), 64'(K2_A));
        wait_round(16);
        chk("enc_K16", 64'({sk, sk_last}), 64'({K16_A, 1'b1}));
        @(negedge clk);
        chk("enc_ready_cycle17", 64'({key_ready, sk_valid}), 64'(2'b10));
        drain_idle();
        chk("enc_valid_cycles", 64'(valid_cycles), 64'(16));
        chk("enc_handshakes", 64'(hs_cnt), 64'(16));

        // Decrypt, full rate.
        send_key(KEY_A, 1'b1);
        hs_cnt = 0;
        @(negedge clk);
        chk("dec_first_sk", 64'({sk, sk_round}), 64'({K16_A, 5'd16}));
        drain_idle();
        chk("dec_handshakes", 64'(hs_cnt), 64'(16));

        // Backpressure held for three cycles at round 5.
        send_key(KEY_A, 1'b0);
        wait_round(4);
        @(posedge clk);
        #1;
        sk_ready = 1'b0;
        @(negedge clk);
        held_sk = sk;
        chk("bp_round", 64'(sk_round), 64'(5));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_hold", 64'({sk, sk_round, sk_last}), 64'({held_sk, 5'd5, 1'b0}));
        end
        @(posedge clk);
        #1;
        sk_ready = 1'b1;
        drain_idle();

        // A key offered mid-run must be ignored.
        send_key(KEY_A, 1'b0);
        wait_round(6);
        @(posedge clk);
        #1;
        key_valid = 1'b1;
        key       = '0;
        decrypt   = 1'b0;
        @(negedge clk);
        chk("busy_key_ready_r7", 64'(key_ready), 64'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("busy_key_ready_r8", 64'(key_ready), 64'(0));
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        drain_idle();

        // Reset mid-run at round 8.
        send_key(KEY_A, 1'b0);
        wait_round(7);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_mid_state", 64'({sk_valid, key_ready, sk_round}), 64'({1'b0, 1'b1, 5'd0}));
        send_key(KEY_A, 1'b0);
        @(negedge clk);
        chk("rst_fresh_K1", 64'(sk), 64'(K1_A));
        drain_idle();

        // Bad parity byte: error flagged, subkeys unchanged.
        send_key(KEY_AP, 1'b0);
        @(negedge clk);
        chk("parity_err", 64'(key_parity_err), 64'(1));
        chk("parity_K1", 64'(sk), 64'(K1_A));
        drain_idle();

        // Random keys, directions and backpressure.
        rdy_rand = 1'b1;
        for (int n = 0; n < 24; n++) begin
            logic [63:0] k;
            logic        d;
            k = {$urandom(), $urandom()};
            d = 1'($urandom_range(0, 1));
            send_key(k, d);
            @(negedge clk);
            chk("rand_parity", 64'(key_parity_err), 64'(model_parity_bad(k)));
            drain_idle();
        end
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;
        sk_ready = 1'b1;

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
